ps2_key_gen: RTL and testbench
==============================

PS2_KEY_GEN -- requirements
Module: ps2_key_gen

Interface
- REQ-001: Parameter FILTER, default 8: consecutive clk_sys cycles a synchronized PS/2 line must hold a level before the filtered level changes.
- REQ-002: Parameter TIMEOUT, default 100000: inter-edge watchdog limit in clk_sys cycles; 17-bit counter.
- REQ-003: clk_sys  in  1  single system clock; all logic on its rising edge.
- REQ-004: RESET_N  in  1  asynchronous, active-low reset.
- REQ-005: ps2_clk_in  in  1  raw PS/2 clock line from the device, asynchronous.
- REQ-006: ps2_data_in  in  1  raw PS/2 data line from the device, asynchronous.
- REQ-007: ps2_key  out  11  event word: [10] toggle, [9] pressed, [8] extended, [7:0] scan code.
- REQ-008: frame_err  out  1  one-cycle pulse on a discarded frame.
- REQ-009: busy  out  1  high whenever the FSM is not in IDLE.

Function
- REQ-010: Both inputs SHALL pass through a 2-flop synchronizer, then a FILTER-cycle stability filter.
- REQ-011: A bit SHALL be sampled from filtered data in the cycle the filtered clock is detected falling.
- REQ-012: FSM states: IDLE, DATA, PARITY, STOP.
- REQ-013: IDLE: an edge with data 0 -> DATA with bit count 0; an edge with data 1 SHALL be ignored.
- REQ-014: DATA: shift bits in LSB first; after the 8th edge -> PARITY.
- REQ-015: PARITY: latch the bit -> STOP; the 8 data bits plus parity SHALL have odd total parity.
- REQ-016: STOP: on the edge, accept only if stop = 1 and parity is good; otherwise pulse frame_err; either way -> IDLE.
- REQ-017: Accepted byte 0xE0 SHALL set the ext flag and emit nothing.
- REQ-018: Accepted byte 0xF0 SHALL set the brk flag and emit nothing.
- REQ-019: Any other accepted byte (0xE1 and 0xAA included) SHALL be emitted.
- REQ-020: Emit, registered one cycle after the stop edge: ps2_key[7:0] = byte, [8] = ext, [9] = ~brk, [10] inverted; then ext and brk cleared.
- REQ-021: frame_err SHALL also clear ext and brk; ps2_key SHALL be unchanged on any error.
- REQ-022: ps2_key[10] SHALL toggle exactly once per emitted event; consumers detect events by toggle change.
- REQ-023: The toggle SHALL wrap 1 -> 0 freely.
- REQ-024: An edge arriving in the same cycle as the emit SHALL be processed normally; no edge is lost.
- REQ-025: frame_err SHALL be high for exactly one cycle per discarded frame; busy SHALL drop the cycle after the STOP edge.

Reset
- REQ-026: RESET_N low SHALL immediately force ps2_key = 0, frame_err = 0, busy = 0, FSM = IDLE, ext = brk = 0, shift register = 0, watchdog = 0.
- REQ-027: Synchronizer and filter state SHALL reset to 1 (idle line level), so release does not create a false falling edge.
- REQ-028: Reset asserted mid-frame SHALL discard the partial frame and pending prefixes without pulsing frame_err.

Configuration
- REQ-029: Macro PS2_KEY_GEN_TIMEOUT_EN, when defined, SHALL enable the inter-edge watchdog.
- REQ-030: With the macro, in any non-IDLE state the watchdog SHALL count cycles since the last filtered falling edge.
- REQ-031: With the macro, on reaching TIMEOUT the FSM SHALL return to IDLE, pulse frame_err, clear ext and brk, and zero the counter.
- REQ-032: Without the macro, no counter SHALL exist; a partial frame persists until further edges complete it.

Verification
- REQ-033: After reset, send frame 0x1C -> ps2_key = 11'h61C one cycle after stop edge; frame_err stays 0.
- REQ-034: Then send E0, F0, 75 -> exactly one event, ps2_key = 11'h175; no change after E0 or F0.
- REQ-035: Send 0x29 with even parity -> frame_err one-cycle pulse, ps2_key unchanged; next good 0x29 -> toggle flips, [8:0] = 9'h029 with pressed = 1.
- REQ-036: With PS2_KEY_GEN_TIMEOUT_EN: stop after 5 bits, idle TIMEOUT+10 cycles -> one frame_err pulse, busy = 0; following frame 0x14 decodes to [9:0] = 10'h214.
- REQ-037: Send F0, assert RESET_N low mid-next-frame, release, send 0x14 -> ps2_key = 11'h614 (pressed, not break).
- REQ-038: Inject a ps2_clk_in low glitch of FILTER-2 cycles in IDLE and mid-frame -> no bit sampled, no state change.

Source files
------------

// File: rtl/ps2_key_gen.sv
// PS/2 keyboard receiver: filters the raw lines, decodes frames and emits toggle-flagged key events.
// Define PS2_KEY_GEN_TIMEOUT_EN to enable the inter-edge watchdog that abandons stalled frames.
module ps2_key_gen #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        frame_err,
  output logic        busy
);

  localparam int FW = $clog2(FILTER + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic          clk_filt_d;
  logic          data_filt;
  logic [FW-1:0] clk_cnt;
  logic [FW-1:0] data_cnt;
  logic          clk_fall;
  logic          timeout_hit;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_bit;
  logic          ext;
  logic          brk;

  // Synchronizers idle high so releasing reset never fakes a falling edge.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
    end
  end

  // A filtered line only follows its input after FILTER consecutive differing samples.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      data_filt  <= 1'b1;
      clk_cnt    <= '0;
      data_cnt   <= '0;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        clk_cnt <= '0;
      end else if (clk_cnt == FW'(FILTER - 1)) begin
        clk_filt <= clk_sync[1];
        clk_cnt  <= '0;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
      if (data_sync[1] == data_filt) begin
        data_cnt <= '0;
      end else if (data_cnt == FW'(FILTER - 1)) begin
        data_filt <= data_sync[1];
        data_cnt  <= '0;
      end else begin
        data_cnt <= data_cnt + 1'b1;
      end
    end
  end

  assign clk_fall = clk_filt_d & ~clk_filt;

`ifdef PS2_KEY_GEN_TIMEOUT_EN
  logic [16:0] wd_cnt;

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      wd_cnt <= '0;
    end else if (state == IDLE || clk_fall || timeout_hit) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state != IDLE) && (wd_cnt == 17'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  // Frame decoder; prefixes E0/F0 are remembered until the next emitted or discarded byte.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      ps2_key    <= '0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (timeout_hit) begin
        state     <= IDLE;
        busy      <= 1'b0;
        frame_err <= 1'b1;
        ext       <= 1'b0;
        brk       <= 1'b0;
      end else if (clk_fall) begin
        case (state)
          IDLE: begin
            if (!data_filt) begin
              state   <= DATA;
              busy    <= 1'b1;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= {data_filt, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= data_filt;
            state      <= STOP;
          end
          STOP: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (data_filt && (^{shift, parity_bit})) begin
              if (shift == 8'hE0) begin
                ext <= 1'b1;
              end else if (shift == 8'hF0) begin
                brk <= 1'b1;
              end else begin
                ps2_key <= {~ps2_key[10], ~brk, ext, shift};
                ext     <= 1'b0;
                brk     <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_gen.sv
// Directed bench for ps2_key_gen: serial PS/2 frames with hand-computed key words and error pulses.
module tb_ps2_key_gen;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 3000;
  localparam int HALF    = 20;

  logic        clk_sys = 1'b0;
  logic        RESET_N;
  logic        ps2_clk_in;
  logic        ps2_data_in;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int err_cycles = 0;
  int key_changes = 0;
  logic [10:0] key_prev = '0;
  int err_mark;
  int key_mark;

  ps2_key_gen #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys     (clk_sys),
    .RESET_N     (RESET_N),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_key     (ps2_key),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Counts frame_err high cycles and ps2_key changes so tests can check deltas.
  always @(posedge clk_sys) begin
    if (frame_err === 1'b1) err_cycles++;
    if (ps2_key !== key_prev) key_changes++;
    key_prev = ps2_key;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_sys);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par,
                                             input logic stop);
    return {stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bit(input logic b);
    ps2_data_in = b;
    wait_cycles(HALF / 2);
    ps2_clk_in = 1'b0;
    wait_cycles(HALF);
    ps2_clk_in = 1'b1;
    wait_cycles(HALF / 2);
  endtask

  task automatic applyStimulus(input logic [10:0] frame, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(frame[i]);
  endtask

  task automatic send_frame(input logic [10:0] frame);
    applyStimulus(frame, 0, 10);
    ps2_data_in = 1'b1;
    wait_cycles(30);
    @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(make_frame(b, 1'b0, 1'b1));
  endtask

  task automatic clk_glitch();
    ps2_clk_in = 1'b0;
    wait_cycles(FILTER - 2);
    ps2_clk_in = 1'b1;
    wait_cycles(30);
    @(negedge clk_sys);
  endtask

  initial begin
    RESET_N     = 1'b0;
    ps2_clk_in  = 1'b1;
    ps2_data_in = 1'b1;
    wait_cycles(5);
    @(negedge clk_sys);
    checkOutput("reset_key", 32'(ps2_key), 32'h000);
    checkOutput("reset_err", 32'(frame_err), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    RESET_N = 1'b1;
    wait_cycles(5);

    err_mark = err_cycles;
    send_byte(8'h1C);
    checkOutput("key_1c", 32'(ps2_key), 32'h61C);
    checkOutput("err_1c", 32'(err_cycles - err_mark), 32'd0);
    checkOutput("busy_after_1c", 32'(busy), 32'h0);

    key_mark = key_changes;
    send_byte(8'hE0);
    checkOutput("key_after_e0", 32'(ps2_key), 32'h61C);
    send_byte(8'hF0);
    checkOutput("key_after_f0", 32'(ps2_key), 32'h61C);
    send_byte(8'h75);
    checkOutput("key_ext_brk_75", 32'(ps2_key), 32'h175);
    checkOutput("events_e0f075", 32'(key_changes - key_mark), 32'd1);

    err_mark = err_cycles;
    send_frame(make_frame(8'h29, 1'b1, 1'b1));
    checkOutput("err_bad_parity", 32'(err_cycles - err_mark), 32'd1);
    checkOutput("key_bad_parity", 32'(ps2_key), 32'h175);
    send_byte(8'h29);
    checkOutput("key_good_29", 32'(ps2_key), 32'h629);

    err_mark = err_cycles;
    clk_glitch();
    checkOutput("glitch_idle_busy", 32'(busy), 32'h0);
    checkOutput("glitch_idle_key", 32'(ps2_key), 32'h629);
    applyStimulus(make_frame(8'h14, 1'b0, 1'b1), 0, 3);
    clk_glitch();
    checkOutput("glitch_mid_busy", 32'(busy), 32'h1);
    applyStimulus(make_frame(8'h14, 1'b0, 1'b1), 4, 10);
    wait_cycles(30);
    @(negedge clk_sys);
    checkOutput("glitch_mid_key", 32'(ps2_key), 32'h214);
    checkOutput("glitch_err", 32'(err_cycles - err_mark), 32'd0);

    err_mark = err_cycles;
    send_frame(make_frame(8'h33, 1'b0, 1'b0));
    checkOutput("err_bad_stop", 32'(err_cycles - err_mark), 32'd1);
    checkOutput("key_bad_stop", 32'(ps2_key), 32'h214);

    send_byte(8'hE1);
    checkOutput("key_e1", 32'(ps2_key), 32'h6E1);
    send_byte(8'hAA);
    checkOutput("key_aa", 32'(ps2_key), 32'h2AA);

`ifdef PS2_KEY_GEN_TIMEOUT_EN
    send_byte(8'hE0);
    err_mark = err_cycles;
    applyStimulus(make_frame(8'h14, 1'b0, 1'b1), 0, 4);
    ps2_data_in = 1'b1;
    wait_cycles(TIMEOUT + 10);
    @(negedge clk_sys);
    checkOutput("timeout_err", 32'(err_cycles - err_mark), 32'd1);
    checkOutput("timeout_busy", 32'(busy), 32'h0);
    send_byte(8'h14);
    checkOutput("key_after_timeout", 32'(ps2_key), 32'h614);
`else
    err_mark = err_cycles;
    applyStimulus(make_frame(8'h14, 1'b0, 1'b1), 0, 4);
    wait_cycles(TIMEOUT + 10);
    @(negedge clk_sys);
    checkOutput("partial_busy", 32'(busy), 32'h1);
    checkOutput("partial_err", 32'(err_cycles - err_mark), 32'd0);
    applyStimulus(make_frame(8'h14, 1'b0, 1'b1), 5, 10);
    wait_cycles(30);
    @(negedge clk_sys);
    checkOutput("key_partial_done", 32'(ps2_key), 32'h614);
`endif

    send_byte(8'hF0);
    err_mark = err_cycles;
    applyStimulus(make_frame(8'h14, 1'b0, 1'b1), 0, 3);
    RESET_N = 1'b0;
    #1;
    checkOutput("midreset_key", 32'(ps2_key), 32'h000);
    checkOutput("midreset_busy", 32'(busy), 32'h0);
    ps2_data_in = 1'b1;
    ps2_clk_in  = 1'b1;
    wait_cycles(5);
    RESET_N = 1'b1;
    wait_cycles(5);
    send_byte(8'h14);
    checkOutput("key_after_reset", 32'(ps2_key), 32'h614);
    checkOutput("midreset_err", 32'(err_cycles - err_mark), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
